// File: rtl/pic_pkg.sv
// Shared types and constants for the 8259A-style interrupt controller blocks.
package pic_pkg;

  localparam int NUM_IRQ = 8;
  localparam int LEVEL_W = 3;
  localparam logic [LEVEL_W-1:0] SPURIOUS_LEVEL = 3'd7;

  typedef enum logic {
    IDLE      = 1'b0,
    ACK1_DONE = 1'b1
  } isc_state_e;

  function automatic logic [NUM_IRQ-1:0] level_mask(input logic [LEVEL_W-1:0] lvl);
    return NUM_IRQ'(1) << lvl;
  endfunction

endpackage

// File: rtl/in_service_control_if.sv
// Signal bundle between the in-service controller and its surroundings
// (resolver, INTA synchroniser, command decoder, data bus).
interface in_service_control_if;
  import pic_pkg::*;

  logic [NUM_IRQ-1:0] interruptVector;
  logic               intaStrobe;
  logic [4:0]         vectorBase;
  logic               autoEoi;
  logic               eoiCmd;
  logic               specificEoi;
  logic [LEVEL_W-1:0] eoiLevel;
  logic [NUM_IRQ-1:0] ISR;
  logic [NUM_IRQ-1:0] irrClear;
  logic               INT;
  logic [7:0]         dataOut;
  logic               dataOutValid;

  modport slave (
    input  interruptVector, intaStrobe, vectorBase, autoEoi,
           eoiCmd, specificEoi, eoiLevel,
    output ISR, irrClear, INT, dataOut, dataOutValid
  );

  modport master (
    output interruptVector, intaStrobe, vectorBase, autoEoi,
           eoiCmd, specificEoi, eoiLevel,
    input  ISR, irrClear, INT, dataOut, dataOutValid
  );
endinterface

// File: rtl/in_service_control_lowest_set_index.sv
// Priority encoder: index of the lowest set bit, plus a valid flag when any bit is set.
module lowest_set_index
  import pic_pkg::*;
(
  input  logic [NUM_IRQ-1:0] i_vec,
  output logic [LEVEL_W-1:0] o_index,
  output logic               o_valid
);

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    o_index = '0;
    o_valid = 1'b0;
    // Scan downward so the last hit, i.e. the lowest index, is the one kept.
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (i_vec[i]) begin
        o_index = LEVEL_W'(i);
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/in_service_control.sv
// In-service control: runs the two-pulse 8086 INTA sequence, owns the ISR,
// and applies non-specific, specific and automatic EOI.
module in_service_control
  import pic_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  in_service_control_if.slave bus
);

  isc_state_e         r_state;
  logic [LEVEL_W-1:0] r_active_level;
  logic               r_spurious;
  logic [NUM_IRQ-1:0] r_isr;
  logic [NUM_IRQ-1:0] r_irr_clear;
  logic               r_int;
  logic [7:0]         r_data_out;
  logic               r_data_valid;

  logic [LEVEL_W-1:0] w_vec_idx;
  logic               w_vec_valid;
  logic [LEVEL_W-1:0] w_eoi_idx;
  logic               w_eoi_valid;
  logic               w_first_ack;
  logic               w_second_ack;
  logic [NUM_IRQ-1:0] w_set_mask;
  logic [NUM_IRQ-1:0] w_clr_mask;
  logic [NUM_IRQ-1:0] w_isr_next;

  lowest_set_index u_vec_enc (
    .i_vec   (bus.interruptVector),
    .o_index (w_vec_idx),
    .o_valid (w_vec_valid)
  );

  // Non-specific EOI searches the ISR as it stands before this cycle's set.
  lowest_set_index u_eoi_enc (
    .i_vec   (r_isr),
    .o_index (w_eoi_idx),
    .o_valid (w_eoi_valid)
  );

  always_comb begin
    w_first_ack  = (r_state == IDLE) && bus.intaStrobe;
    w_second_ack = (r_state == ACK1_DONE) && bus.intaStrobe;
    w_set_mask   = (w_first_ack && w_vec_valid) ? level_mask(w_vec_idx) : '0;

    w_clr_mask = '0;
    if (bus.eoiCmd) begin
      if (bus.specificEoi)
        w_clr_mask = w_clr_mask | level_mask(bus.eoiLevel);
      else if (w_eoi_valid)
        w_clr_mask = w_clr_mask | level_mask(w_eoi_idx);
    end
    if (w_second_ack && bus.autoEoi && !r_spurious)
      w_clr_mask = w_clr_mask | level_mask(r_active_level);

    // Set is applied after the clears so a same-bit collision keeps the bit.
    w_isr_next = (r_isr & ~w_clr_mask) | w_set_mask;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= IDLE;
      r_active_level <= '0;
      r_spurious     <= 1'b0;
      r_isr          <= '0;
      r_irr_clear    <= '0;
      r_int          <= 1'b0;
      r_data_out     <= '0;
      r_data_valid   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_isr        <= w_isr_next;
      r_irr_clear  <= w_set_mask;
      r_data_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.intaStrobe) begin
            r_active_level <= w_vec_valid ? w_vec_idx : SPURIOUS_LEVEL;
            r_spurious     <= !w_vec_valid;
            r_int          <= 1'b0;
            r_state        <= ACK1_DONE;
          end else begin
            r_int <= |bus.interruptVector;
          end
        end
        ACK1_DONE: begin
          // Level is frozen between the acknowledges; INT stays low.
          r_int <= 1'b0;
          if (bus.intaStrobe) begin
            r_data_out   <= {bus.vectorBase, r_active_level};
            r_data_valid <= 1'b1;
            r_state      <= IDLE;
          end
        end
      endcase
    end
  end

  assign bus.ISR          = r_isr;
  assign bus.irrClear     = r_irr_clear;
  assign bus.INT          = r_int;
  assign bus.dataOut      = r_data_out;
  assign bus.dataOutValid = r_data_valid;

endmodule

// File: tb/tb_in_service_control.sv
// Scoreboard bench for in_service_control: directed scenarios plus random traffic
// checked against a behavioural model of the acknowledge / EOI rules.
module tb_in_service_control;
  import pic_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  in_service_control_if bus ();

  in_service_control dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] isr;
    logic       intr;
  } cyc_t;

  cyc_t       cyc_q[$];
  logic [7:0] irr_q[$];
  logic [7:0] data_q[$];

  // Behavioural model state
  bit [7:0] m_isr;
  bit       m_in_ack;
  bit       m_spur;
  bit       m_int;
  int       m_level;

  logic [4:0] cur_vb;
  bit         cur_aeoi;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int lowest(input bit [7:0] v);
    for (int i = 0; i < 8; i++)
      if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_isr    = '0;
    m_in_ack = 1'b0;
    m_spur   = 1'b0;
    m_int    = 1'b0;
    m_level  = 0;
  endtask

  // One clock of stimulus; the model's expected post-edge response is queued.
  task automatic step(input logic [7:0] iv, input bit inta, input bit eoi,
                      input bit spec, input logic [2:0] lvl);
    bit [7:0] pre;
    bit [7:0] clr;
    bit [7:0] set;
    @(negedge clk);
    reset               = 1'b0;
    bus.interruptVector = iv;
    bus.intaStrobe      = inta;
    bus.vectorBase      = cur_vb;
    bus.autoEoi         = cur_aeoi;
    bus.eoiCmd          = eoi;
    bus.specificEoi     = spec;
    bus.eoiLevel        = lvl;

    pre = m_isr;
    clr = '0;
    set = '0;
    if (!m_in_ack) begin
      if (inta) begin
        if (iv != 0) begin
          m_level = lowest(iv);
          m_spur  = 1'b0;
          set     = 8'(1) << m_level;
          irr_q.push_back(set);
        end else begin
          m_level = 7;
          m_spur  = 1'b1;
        end
        m_in_ack = 1'b1;
        m_int    = 1'b0;
      end else begin
        m_int = (iv != 0);
      end
    end else begin
      m_int = 1'b0;
      if (inta) begin
        data_q.push_back({cur_vb, 3'(m_level)});
        if (cur_aeoi && !m_spur) clr[m_level] = 1'b1;
        m_in_ack = 1'b0;
      end
    end
    if (eoi) begin
      if (spec) clr[lvl] = 1'b1;
      else if (pre != 0) clr[lowest(pre)] = 1'b1;
    end
    m_isr = (pre & ~clr) | set;
    cyc_q.push_back('{isr: m_isr, intr: m_int});
  endtask

  task automatic idle(input logic [7:0] iv);
    step(iv, 1'b0, 1'b0, 1'b0, 3'd0);
  endtask

  // Full two-INTA acknowledge of a single request line.
  task automatic ack(input logic [7:0] iv);
    step(iv, 1'b1, 1'b0, 1'b0, 3'd0);
    step(8'h00, 1'b1, 1'b0, 1'b0, 3'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset          = 1'b1;
    bus.intaStrobe = 1'b0;
    bus.eoiCmd     = 1'b0;
    #1;
    check("reset_isr_immediate", bus.ISR, 8'h00);
    check("reset_int_immediate", bus.INT, 1'b0);
    check("reset_irr_immediate", bus.irrClear, 8'h00);
    check("reset_valid_immediate", bus.dataOutValid, 1'b0);
    model_reset();
    cyc_q.push_back('{isr: 8'h00, intr: 1'b0});
  endtask

  // Monitor: compares whatever the DUT presents against the queued expectations.
  initial begin
    cyc_t e;
    forever begin
      @(posedge clk);
      #1;
      if (bus.irrClear != 0) begin
        if (irr_q.size() == 0) check("irrClear_unexpected", bus.irrClear, 8'h00);
        else check("irrClear", bus.irrClear, irr_q.pop_front());
      end
      if (bus.dataOutValid) begin
        if (data_q.size() == 0) check("dataOutValid_unexpected", bus.dataOutValid, 1'b0);
        else check("dataOut", bus.dataOut, data_q.pop_front());
      end
      if (cyc_q.size() > 0) begin
        e = cyc_q.pop_front();
        check("ISR", bus.ISR, e.isr);
        check("INT", bus.INT, e.intr);
      end
    end
  end

  initial begin
    reset               = 1'b1;
    bus.interruptVector = '0;
    bus.intaStrobe      = 1'b0;
    bus.vectorBase      = '0;
    bus.autoEoi         = 1'b0;
    bus.eoiCmd          = 1'b0;
    bus.specificEoi     = 1'b0;
    bus.eoiLevel        = '0;
    cur_vb              = '0;
    cur_aeoi            = 1'b0;
    model_reset();

    repeat (2) @(posedge clk);
    #1;
    check("init_isr", bus.ISR, 8'h00);
    check("init_int", bus.INT, 1'b0);
    check("init_irr", bus.irrClear, 8'h00);
    check("init_dout", bus.dataOut, 8'h00);
    check("init_valid", bus.dataOutValid, 1'b0);

    // Normal cycle: IR2, base 0x11 -> vector 0x8A, ISR stays 0x04
    cur_vb = 5'h11; cur_aeoi = 1'b0;
    idle(8'h04); idle(8'h04);
    step(8'h04, 1'b1, 1'b0, 1'b0, 3'd0);
    idle(8'h04);
    step(8'h04, 1'b1, 1'b0, 1'b0, 3'd0);
    idle(8'h00); idle(8'h00);
    step(8'h00, 1'b0, 1'b1, 1'b0, 3'd0);

    // AEOI: ISR clears with the vector
    cur_aeoi = 1'b1;
    idle(8'h04);
    ack(8'h04);
    idle(8'h00);

    // Spurious: base 0x08 -> 0x47, no ISR / irrClear
    cur_aeoi = 1'b0; cur_vb = 5'h08;
    step(8'h00, 1'b1, 1'b0, 1'b0, 3'd0);
    idle(8'h00);
    step(8'h00, 1'b1, 1'b0, 1'b0, 3'd0);
    idle(8'h00);

    // Freeze: vector moves to IR0 between acknowledges, level 5 still served
    idle(8'h20);
    step(8'h20, 1'b1, 1'b0, 1'b0, 3'd0);
    idle(8'h01); idle(8'h01);
    step(8'h01, 1'b1, 1'b0, 1'b0, 3'd0);
    idle(8'h00);
    step(8'h00, 1'b0, 1'b1, 1'b1, 3'd5);

    // EOI: build ISR 0x29 then non-specific, specific 5, specific 2 (no-op)
    ack(8'h20); ack(8'h08); ack(8'h01);
    step(8'h00, 1'b0, 1'b1, 1'b0, 3'd0);
    step(8'h00, 1'b0, 1'b1, 1'b1, 3'd5);
    step(8'h00, 1'b0, 1'b1, 1'b1, 3'd2);
    step(8'h00, 1'b0, 1'b1, 1'b1, 3'd3);
    // Same-bit set and specific EOI: set wins
    step(8'h02, 1'b1, 1'b1, 1'b1, 3'd1);
    step(8'h00, 1'b1, 1'b1, 1'b0, 3'd0);
    idle(8'h00);

    // Reset between the acknowledges, then a fresh first INTA
    step(8'h04, 1'b1, 1'b0, 1'b0, 3'd0);
    do_reset();
    step(8'h04, 1'b1, 1'b0, 1'b0, 3'd0);
    idle(8'h00);
    step(8'h00, 1'b1, 1'b0, 1'b0, 3'd0);
    step(8'h00, 1'b0, 1'b1, 1'b0, 3'd0);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      logic [7:0] iv;
      int         sel;
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        sel = $urandom_range(0, 3);
        if (sel == 0) iv = 8'h00;
        else if (sel == 1) iv = 8'(1) << $urandom_range(0, 7);
        else iv = 8'($urandom);
        if ($urandom_range(0, 15) == 0) cur_vb = 5'($urandom);
        cur_aeoi = 1'($urandom);
        step(iv, ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0),
             1'($urandom), 3'($urandom));
      end
    end

    idle(8'h00); idle(8'h00);
    @(posedge clk);
    #2;
    check("drain_cyc_q", cyc_q.size(), 0);
    check("drain_irr_q", irr_q.size(), 0);
    check("drain_data_q", data_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
